// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_pkg
//  Purpose  : Shared constants and helpers for the vectoring/rotation CORDIC.
//  Revision : 1.0  initial release
// ============================================================================
package cordic_pkg;

    localparam logic MODE_VEC = 1'b0;
    localparam logic MODE_ROT = 1'b1;

    // CORDIC gain compensation factor 0.60725 in Q1.14
    localparam logic signed [15:0] K_Q14 = 16'sh26DD;

    function automatic int nstg(input int iter, input int ips);
        return (iter + ips - 1) / ips;
    endfunction

    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int bw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vr_stage.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vr_stage
//  Purpose  : Up to IPS chained micro-rotations followed by an enabled register.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_vr_stage
    import cordic_pkg::*;
#(
    parameter int W    = 20,
    parameter int ITER = 14,
    parameter int IPS  = 2,
    parameter int BASE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                src_valid,
    input  logic                src_mode,
    input  logic signed [W-1:0] src_x,
    input  logic signed [W-1:0] src_y,
    input  logic [ITER:0]       src_d,
    output logic                valid,
    output logic                mode,
    output logic signed [W-1:0] x,
    output logic signed [W-1:0] y,
    output logic [ITER:0]       d
);

    // The final stage may carry fewer iterations than IPS
    localparam int NI = ((ITER - BASE) < IPS) ? (ITER - BASE) : IPS;

    logic signed [W-1:0] w_x;
    logic signed [W-1:0] w_y;
    logic signed [W-1:0] w_xs;
    logic signed [W-1:0] w_ys;
    logic signed [W-1:0] w_xn;
    logic [ITER:0]       w_d;
    logic                w_dk;

    always_comb begin
        w_x  = src_x;
        w_y  = src_y;
        w_d  = src_d;
        w_xs = '0;
        w_ys = '0;
        w_xn = '0;
        w_dk = 1'b0;
        for (int i = 0; i < NI; i++) begin
            w_dk = (src_mode == MODE_VEC) ? (w_x[W-1] ^ w_y[W-1]) : src_d[BASE + i];
            w_xs = w_x >>> (BASE + i);
            w_ys = w_y >>> (BASE + i);
            w_xn = w_dk ? (w_x - w_ys) : (w_x + w_ys);
            w_y  = w_dk ? (w_y + w_xs) : (w_y - w_xs);
            w_x  = w_xn;
            w_d[BASE + i] = w_dk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            mode  <= 1'b0;
            x     <= '0;
            y     <= '0;
            d     <= '0;
        end else if (en) begin
            valid <= src_valid;
            mode  <= src_mode;
            x     <= w_x;
            y     <= w_y;
            d     <= w_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_vr_engine.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vr_engine
//  Purpose  : Pipelined vectoring/rotation CORDIC with stall handshake and
//             quadrant pre-rotation. Define CORDIC_GAIN_COMP_EN to add a
//             gain-compensation multiply stage.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_vr_engine
    import cordic_pkg::*;
#(
    parameter int BITWIDTH = 18,
    parameter int ITER     = 14,
    parameter int IPS      = 2,
    parameter int GUARD    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       mode_i,
    input  logic signed [BITWIDTH-1:0] X_i,
    input  logic signed [BITWIDTH-1:0] Y_i,
    input  logic [ITER:0]              d_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       mode_o,
    output logic signed [BITWIDTH-1:0] X_o,
    output logic signed [BITWIDTH-1:0] Y_o,
    output logic [ITER:0]              d_o
);

    localparam int W    = BITWIDTH + GUARD;
    localparam int NSTG = nstg(ITER, IPS);

    logic                w_q;
    logic signed [W-1:0] w_xe;
    logic signed [W-1:0] w_ye;
    logic [ITER:0]       w_d0;

    logic                r_valid0;
    logic                r_mode0;
    logic signed [W-1:0] r_x0;
    logic signed [W-1:0] r_y0;
    logic [ITER:0]       r_d0;

    logic                stg_valid [NSTG+1];
    logic                stg_mode  [NSTG+1];
    logic signed [W-1:0] stg_x     [NSTG+1];
    logic signed [W-1:0] stg_y     [NSTG+1];
    logic [ITER:0]       stg_d     [NSTG+1];

    logic                f_valid;
    logic                f_mode;
    logic signed [W-1:0] f_x;
    logic signed [W-1:0] f_y;
    logic [ITER:0]       f_d;

    // Every register advances exactly when the downstream side accepts
    assign ready_o = ready_i;

    // Sign-extend first so that the most negative input negates without wrapping
    assign w_q  = (mode_i == MODE_VEC) ? X_i[BITWIDTH-1] : d_i[ITER];
    assign w_xe = {{GUARD{X_i[BITWIDTH-1]}}, X_i};
    assign w_ye = {{GUARD{Y_i[BITWIDTH-1]}}, Y_i};
    assign w_d0 = (mode_i == MODE_VEC) ? {w_q, {ITER{1'b0}}} : d_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid0 <= 1'b0;
            r_mode0  <= 1'b0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_d0     <= '0;
        end else if (ready_i) begin
            r_valid0 <= valid_i;
            r_mode0  <= mode_i;
            r_x0     <= w_q ? -w_xe : w_xe;
            r_y0     <= w_q ? -w_ye : w_ye;
            r_d0     <= w_d0;
        end
    end

    assign stg_valid[0] = r_valid0;
    assign stg_mode[0]  = r_mode0;
    assign stg_x[0]     = r_x0;
    assign stg_y[0]     = r_y0;
    assign stg_d[0]     = r_d0;

    generate
        for (genvar j = 0; j < NSTG; j++) begin : g_stage
            cordic_vr_stage #(
                .W    (W),
                .ITER (ITER),
                .IPS  (IPS),
                .BASE (j * IPS)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (ready_i),
                .src_valid (stg_valid[j]),
                .src_mode  (stg_mode[j]),
                .src_x     (stg_x[j]),
                .src_y     (stg_y[j]),
                .src_d     (stg_d[j]),
                .valid     (stg_valid[j+1]),
                .mode      (stg_mode[j+1]),
                .x         (stg_x[j+1]),
                .y         (stg_y[j+1]),
                .d         (stg_d[j+1])
            );
        end
    endgenerate

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = W + 16;
    localparam logic signed [PW-1:0] RND = PW'(8192);

    logic signed [PW-1:0] w_px;
    logic signed [PW-1:0] w_py;
    logic                 r_gvalid;
    logic                 r_gmode;
    logic signed [W-1:0]  r_gx;
    logic signed [W-1:0]  r_gy;
    logic [ITER:0]        r_gd;

    // Round half-up at bit 14 of the Q1.14 product
    assign w_px = PW'(stg_x[NSTG]) * PW'(K_Q14) + RND;
    assign w_py = PW'(stg_y[NSTG]) * PW'(K_Q14) + RND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gvalid <= 1'b0;
            r_gmode  <= 1'b0;
            r_gx     <= '0;
            r_gy     <= '0;
            r_gd     <= '0;
        end else if (ready_i) begin
            r_gvalid <= stg_valid[NSTG];
            r_gmode  <= stg_mode[NSTG];
            r_gx     <= W'(w_px >>> 14);
            r_gy     <= W'(w_py >>> 14);
            r_gd     <= stg_d[NSTG];
        end
    end

    assign f_valid = r_gvalid;
    assign f_mode  = r_gmode;
    assign f_x     = r_gx;
    assign f_y     = r_gy;
    assign f_d     = r_gd;
`else
    assign f_valid = stg_valid[NSTG];
    assign f_mode  = stg_mode[NSTG];
    assign f_x     = stg_x[NSTG];
    assign f_y     = stg_y[NSTG];
    assign f_d     = stg_d[NSTG];
`endif

    assign valid_o = f_valid;
    assign mode_o  = f_mode;
    assign X_o     = BITWIDTH'(sat(32'(f_x), BITWIDTH));
    assign Y_o     = BITWIDTH'(sat(32'(f_y), BITWIDTH));
    assign d_o     = (f_mode == MODE_ROT) ? '0 : f_d;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vr_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_vr_engine
//  Purpose  : Randomised scoreboard bench for cordic_vr_engine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_vr_engine;

    localparam int BW   = 18;
    localparam int ITER = 14;
    localparam int IPS  = 2;
    localparam int DW   = ITER + 1;
    localparam int NSTG = (ITER + IPS - 1) / IPS;
    localparam int MAXV = (1 << (BW - 1)) - 1;
    localparam int MINV = -(1 << (BW - 1));
`ifdef CORDIC_GAIN_COMP_EN
    localparam bit GAIN_COMP = 1'b1;
    localparam int LAT       = NSTG + 2;
    localparam int E_VEC45   = 1414;
    localparam int E_ROT45   = 707;
    localparam int E_NEG500  = 500;
    localparam int TOL_X     = 5;
`else
    localparam bit GAIN_COMP = 1'b0;
    localparam int LAT       = NSTG + 1;
    localparam int E_VEC45   = 2329;
    localparam int E_ROT45   = 1164;
    localparam int E_NEG500  = 823;
    localparam int TOL_X     = 8;
`endif
    localparam int TOL_Y = 4;

    typedef struct {
        logic          mode;
        int            x;
        int            y;
        logic [ITER:0] d;
    } sb_entry_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 valid_i = 1'b0;
    logic                 ready_i = 1'b0;
    logic                 mode_i = 1'b0;
    logic signed [BW-1:0] X_i = '0;
    logic signed [BW-1:0] Y_i = '0;
    logic [ITER:0]        d_i = '0;
    logic                 ready_o;
    logic                 valid_o;
    logic                 mode_o;
    logic signed [BW-1:0] X_o;
    logic signed [BW-1:0] Y_o;
    logic [ITER:0]        d_o;

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_out = 0;
    int            last_x = 0;
    int            last_y = 0;
    logic [ITER:0] last_d = '0;
    sb_entry_t     scb[$];

    cordic_vr_engine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mode_i  (mode_i),
        .X_i     (X_i),
        .Y_i     (Y_i),
        .d_i     (d_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .mode_o  (mode_o),
        .X_o     (X_o),
        .Y_o     (Y_o),
        .d_o     (d_o)
    );

    always #5 clk = ~clk;

    function automatic int clip(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Reference: half-turn pre-rotation, ITER shift-add rotations, optional gain, clip
    function automatic sb_entry_t model(input logic m, input int xi, input int yi,
                                        input logic [ITER:0] di);
        sb_entry_t     r;
        int            a, b, sa, sbv, t;
        logic          q, dk;
        logic [ITER:0] dw;
        q  = (m == 1'b0) ? (xi < 0) : di[ITER];
        a  = q ? -xi : xi;
        b  = q ? -yi : yi;
        dw = '0;
        for (int k = 0; k < ITER; k++) begin
            dk  = (m == 1'b0) ? ((a < 0) != (b < 0)) : di[k];
            sa  = a >>> k;
            sbv = b >>> k;
            if (dk) begin
                t = a - sbv;
                b = b + sa;
            end else begin
                t = a + sbv;
                b = b - sa;
            end
            a     = t;
            dw[k] = dk;
        end
        dw[ITER] = q;
        if (GAIN_COMP) begin
            a = int'((longint'(a) * 64'sd9949 + 64'sd8192) >>> 14);
            b = int'((longint'(b) * 64'sd9949 + 64'sd8192) >>> 14);
        end
        r.mode = m;
        r.x    = clip(a);
        r.y    = clip(b);
        r.d    = m ? '0 : dw;
        return r;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input longint act, input longint req,
                              input longint tol);
        n_checks++;
        if (act > req + tol || act < req - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +-%0d", name, act, req, tol);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && valid_i && ready_o)
            scb.push_back(model(mode_i, int'(X_i), int'(Y_i), d_i));
    end

    always @(negedge clk) begin : compare
        sb_entry_t e;
        if (rst_n && valid_o && ready_i) begin
            if (scb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_output: got valid_o=1 X_o=%0d expected no output", X_o);
            end else begin
                e = scb.pop_front();
                check("out_x", X_o, e.x);
                check("out_y", Y_o, e.y);
                check("out_d", d_o, e.d);
                check("out_mode", mode_o, e.mode);
                last_x = int'(X_o);
                last_y = int'(Y_o);
                last_d = d_o;
                n_out++;
            end
        end
    end

    task automatic send(input logic m, input int x, input int y, input logic [ITER:0] d);
        mode_i  = m;
        X_i     = BW'(x);
        Y_i     = BW'(y);
        d_i     = d;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_out(input int prev, input string name);
        int cyc = 0;
        while (n_out == prev && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (n_out == prev) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no output expected one within 60 cycles", name);
        end
    endtask

    task automatic rand_inputs();
        int sel;
        mode_i = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        X_i = (sel == 0) ? BW'(MINV) : (sel == 1) ? BW'(MAXV) : BW'($urandom);
        sel = $urandom_range(0, 9);
        Y_i = (sel == 0) ? BW'(MINV) : (sel == 1) ? BW'(MAXV) : BW'($urandom);
        d_i = DW'($urandom);
    endtask

    task automatic stream(input int nsamp, input int stall_at, input bit rnd);
        int sent = 0;
        int cyc = 0;
        bit acc;
        rand_inputs();
        ready_i = 1'b1;
        valid_i = 1'b1;
        while (sent < nsamp && cyc < 5000) begin
            @(posedge clk);
            acc = valid_i && ready_i;
            #1;
            cyc++;
            if (acc) begin
                sent++;
                rand_inputs();
            end
            if (rnd) ready_i = ($urandom_range(0, 3) != 0);
            else     ready_i = !(cyc >= stall_at && cyc < stall_at + 3);
            valid_i = (sent < nsamp) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        ready_i = 1'b1;
        valid_i = 1'b0;
        while (scb.size() > 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_pending"}, scb.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        sb_entry_t     m;
        int            prev;
        int            lat;
        logic [ITER:0] d_prev;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_x", X_o, 0);
        check("rst_y", Y_o, 0);
        check("rst_d", d_o, 0);
        check("rst_mode", mode_o, 0);

        // Hand-derived anchors for the reference itself
        m = model(1'b0, 1000, 1000, '0);
        check_near("model_vec45_x", m.x, E_VEC45, TOL_X);
        check_near("model_vec45_y", m.y, 0, TOL_Y);
        check("model_vec45_q", m.d[ITER], 0);
        m = model(1'b1, 1000, 0, m.d);
        check_near("model_rot45_x", m.x, E_ROT45, TOL_X);
        check_near("model_rot45_y", m.y, -E_ROT45, TOL_X);
        m = model(1'b0, -500, 0, '0);
        check("model_neg_q", m.d[ITER], 1);
        check_near("model_neg_x", m.x, E_NEG500, TOL_X);

        rst_n   = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;

        prev = n_out;
        send(1'b0, 1000, 1000, '0);
        lat = 1;
        while (!valid_o && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, LAT);
        wait_out(prev, "vec45");
        check_near("vec45_x", last_x, E_VEC45, TOL_X);
        check_near("vec45_y", last_y, 0, TOL_Y);
        check("vec45_d0", last_d[0], 0);
        check("vec45_q", last_d[ITER], 0);
        d_prev = last_d;

        prev = n_out;
        send(1'b1, 1000, 0, d_prev);
        wait_out(prev, "rot45");
        check_near("rot45_x", last_x, E_ROT45, TOL_X);
        check_near("rot45_y", last_y, -E_ROT45, TOL_X);
        check("rot45_d", last_d, 0);

        prev = n_out;
        send(1'b0, -500, 0, '0);
        wait_out(prev, "neg500");
        check("neg500_q", last_d[ITER], 1);
        check_near("neg500_x", last_x, E_NEG500, TOL_X);
        check_near("neg500_y", last_y, 0, TOL_Y);

        prev = n_out;
        send(1'b0, MAXV, MAXV, '0);
        wait_out(prev, "satur");
        check("satur_x", last_x, MAXV);
        check_near("satur_y", last_y, 0, 63);

        stream(20, 8, 1'b0);
        drain("stall_stream");
        stream(300, 0, 1'b1);
        drain("random_stream");

        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        rst_n = 1'b0;
        scb.delete();
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_x", X_o, 0);
        check("midrst_y", Y_o, 0);
        check("midrst_d", d_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", valid_o, 0);
        end
        prev = n_out;
        send(1'b0, 3000, -2000, '0);
        wait_out(prev, "post_rst");
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
